dpram_port_arbiter: RTL and testbench

DPRAM_PORT_ARBITER -- requirements
Module: dpram_port_arbiter

---
 rtl/dpram_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dpram_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// ----------------------------------------------------------------------------
// dpram_port_arbiter
//
// Shares a single synchronous RAM port between two requesters. A lone request
// is granted in the cycle it is raised. When both requesters ask at once, a
// round-robin pointer gives the grant to the one served least recently. Each
// granted access is issued to the RAM on the following cycle. A granted read
// returns its data to the owning requester two cycles after the grant.
//
// Ports
//   clk_i            single clock, rising edge
//   rst_ni           asynchronous active-low reset
//   reqX_i           requester X access request; weX_i/addrX_i/dinX_i stay
//                    stable until gntX_o
//   weX_i            requester X: 1 = write, 0 = read
//   addrX_i          requester X address
//   dinX_i           requester X write data
//   gntX_o           combinational; request X is accepted at this rising edge
//   rvalidX_o        registered; doutX_o carries requester X read data
//   doutX_o          requester X read data; holds its value while rvalidX_o low
//   ram_we_o         registered RAM write enable
//   ram_addr_o       registered RAM address
//   ram_din_o        registered RAM write data
//   ram_dout_i       RAM read data, valid one cycle after the RAM samples
//                    ram_addr_o
//   conflict_cnt_o   saturating count of cycles with both requests high
// ----------------------------------------------------------------------------
module dpram_port_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] din0_i,
    output logic              gnt0_o,
    output logic              rvalid0_o,
    output logic [DATA_W-1:0] dout0_o,

    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] din1_i,
    output logic              gnt1_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] dout1_o,

    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i,

    output logic [7:0]        conflict_cnt_o
);

    // Round-robin pointer: id of the requester granted most recently.
    logic              last_gnt_q, last_gnt_d;

    // Stage 1: access presented to the RAM.
    logic              ram_we_q,   ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q,  ram_din_d;
    logic              s1_rd_q,    s1_rd_d;
    logic              s1_id_q,    s1_id_d;

    // Stage 2: read data returned to its owner.
    logic              rvalid0_q,  rvalid0_d;
    logic              rvalid1_q,  rvalid1_d;
    logic [DATA_W-1:0] hold0_q,    hold0_d;
    logic [DATA_W-1:0] hold1_q,    hold1_d;

    logic [7:0]        cnt_q,      cnt_d;

    logic              gnt0, gnt1, any_gnt, sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_din;

    // Grants are forced low while reset is asserted. On a tie, requester 0
    // wins only if requester 1 was served last, and vice versa, so the two
    // grants can never be high together.
    always_comb begin
        gnt0     = rst_ni & req0_i & (~req1_i | last_gnt_q);
        gnt1     = rst_ni & req1_i & (~req0_i | ~last_gnt_q);
        any_gnt  = gnt0 | gnt1;
        sel_we   = gnt0 ? we0_i   : we1_i;
        sel_addr = gnt0 ? addr0_i : addr1_i;
        sel_din  = gnt0 ? din0_i  : din1_i;
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt0) begin
            last_gnt_d = 1'b0;
        end else if (gnt1) begin
            last_gnt_d = 1'b1;
        end

        // Without a grant, address and data hold; only the enable drops.
        ram_we_d   = any_gnt & sel_we;
        ram_addr_d = any_gnt ? sel_addr : ram_addr_q;
        ram_din_d  = any_gnt ? sel_din  : ram_din_q;
        s1_rd_d    = any_gnt & ~sel_we;
        s1_id_d    = gnt1;

        rvalid0_d  = s1_rd_q & ~s1_id_q;
        rvalid1_d  = s1_rd_q &  s1_id_q;

        // RAM data is live during the rvalid cycle and captured for holding.
        hold0_d    = rvalid0_q ? ram_dout_i : hold0_q;
        hold1_d    = rvalid1_q ? ram_dout_i : hold1_q;

        cnt_d      = cnt_q;
        if (req0_i && req1_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt_q <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            s1_rd_q    <= 1'b0;
            s1_id_q    <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            hold0_q    <= '0;
            hold1_q    <= '0;
            cnt_q      <= 8'd0;
        end else begin
            last_gnt_q <= last_gnt_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            s1_rd_q    <= s1_rd_d;
            s1_id_q    <= s1_id_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            hold0_q    <= hold0_d;
            hold1_q    <= hold1_d;
            cnt_q      <= cnt_d;
        end
    end

    assign gnt0_o         = gnt0;
    assign gnt1_o         = gnt1;
    assign ram_we_o       = ram_we_q;
    assign ram_addr_o     = ram_addr_q;
    assign ram_din_o      = ram_din_q;
    assign rvalid0_o      = rvalid0_q;
    assign rvalid1_o      = rvalid1_q;
    assign dout0_o        = rvalid0_q ? ram_dout_i : hold0_q;
    assign dout1_o        = rvalid1_q ? ram_dout_i : hold1_q;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dpram_port_arbiter
//
// Directed bench for dpram_port_arbiter with a small synchronous RAM model.
// Stimulus pushes the expected RAM-port and read-return events into queues;
// a monitor compares them against the DUT every cycle.
// ----------------------------------------------------------------------------
module tb_dpram_port_arbiter;

   typedef struct {
      int         cyc;
      logic       we;
      logic [3:0] addr;
      logic [7:0] din;
   } stg_t;

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } rd_t;

   logic       clock = 1'b0;
   logic       rstN;
   logic       req0, we0, req1, we1;
   logic [3:0] addr0, addr1;
   logic [7:0] din0, din1;
   logic       gnt0, gnt1, rvalid0, rvalid1;
   logic [7:0] dout0, dout1;
   logic       ramWe;
   logic [3:0] ramAddr;
   logic [7:0] ramDin;
   logic [7:0] ramDout;
   logic [7:0] conflictCnt;

   int   cyc = 0;
   int   nChecks = 0;
   int   nFail = 0;
   logic track = 1'b1;
   logic monOn = 1'b1;

   stg_t sq[$];
   rd_t  rq0[$];
   rd_t  rq1[$];

   logic [7:0] mem [16];

   logic [3:0] vecA0   [6] = '{4'd0, 4'd2, 4'd2, 4'd4, 4'd4, 4'd6};
   logic [3:0] vecA1   [6] = '{4'd9, 4'd9, 4'd11, 4'd11, 4'd13, 4'd13};
   logic       vecG0   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [7:0] vecData [6] = '{8'h0A, 8'hA9, 8'hA2, 8'hAB, 8'hA4, 8'hAD};

   dpram_port_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk_i          (clock),
      .rst_ni         (rstN),
      .req0_i         (req0),
      .we0_i          (we0),
      .addr0_i        (addr0),
      .din0_i         (din0),
      .gnt0_o         (gnt0),
      .rvalid0_o      (rvalid0),
      .dout0_o        (dout0),
      .req1_i         (req1),
      .we1_i          (we1),
      .addr1_i        (addr1),
      .din1_i         (din1),
      .gnt1_o         (gnt1),
      .rvalid1_o      (rvalid1),
      .dout1_o        (dout1),
      .ram_we_o       (ramWe),
      .ram_addr_o     (ramAddr),
      .ram_din_o      (ramDin),
      .ram_dout_i     (ramDout),
      .conflict_cnt_o (conflictCnt)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   // Cycle stamp shared by stimulus and monitor.
   always @(posedge clock) cyc <= cyc + 1;

   // Read-first synchronous RAM: samples the address at each rising edge
   // and presents the old contents on the next cycle.
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
      ramDout = 8'h00;
      forever begin
         @(posedge clock);
         ramDout <= mem[ramAddr];
         if (ramWe) mem[ramAddr] = ramDin;
      end
   end

   // Counts one comparison and reports it when it does not match.
   function automatic void checkOutput(input string name, input logic [31:0] act,
                                       input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   task automatic drive(input logic r0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                        input logic r1, input logic w1, input logic [3:0] a1, input logic [7:0] d1);
      req0 = r0; we0 = w0; addr0 = a0; din0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; din1 = d1;
   endtask

   // Checks this cycle's grants and records what the accepted access should
   // produce downstream, then advances to just after the next rising edge.
   task automatic applyStimulus(input logic expG0, input logic expG1, input logic [7:0] expData);
      @(negedge clock);
      checkOutput("gnt0", 32'(gnt0), 32'(expG0));
      checkOutput("gnt1", 32'(gnt1), 32'(expG1));
      if (track) begin
         if (expG0) begin
            sq.push_back(stg_t'{cyc + 1, we0, addr0, din0});
            if (!we0) rq0.push_back(rd_t'{cyc + 2, expData});
         end
         if (expG1) begin
            sq.push_back(stg_t'{cyc + 1, we1, addr1, din1});
            if (!we1) rq1.push_back(rd_t'{cyc + 2, expData});
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idleCycles(input int n);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 8'h00);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_gnt0"},    32'(gnt0),        0);
      checkOutput({tag, "_gnt1"},    32'(gnt1),        0);
      checkOutput({tag, "_ram_we"},  32'(ramWe),       0);
      checkOutput({tag, "_ram_addr"},32'(ramAddr),     0);
      checkOutput({tag, "_ram_din"}, 32'(ramDin),      0);
      checkOutput({tag, "_rvalid0"}, 32'(rvalid0),     0);
      checkOutput({tag, "_rvalid1"}, 32'(rvalid1),     0);
      checkOutput({tag, "_dout0"},   32'(dout0),       0);
      checkOutput({tag, "_dout1"},   32'(dout1),       0);
      checkOutput({tag, "_cnt"},     32'(conflictCnt), 0);
   endtask

   // Reset with both requests raised so the grant gating is exercised.
   task automatic applyReset(input string tag);
      rstN = 1'b0;
      drive(1, 0, 0, 0, 1, 0, 0, 0);
      repeat (2) @(posedge clock);
      #1;
      checkResetOutputs(tag);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clock);
      #1;
      rstN = 1'b1;
   endtask

   // Monitor: every cycle out of reset, either the expected event is due and
   // must appear, or the port must sit idle holding its last value.
   initial begin
      stg_t       s;
      rd_t        r;
      logic [3:0] lastAddr = 4'h0;
      logic [7:0] lastDin  = 8'h00;
      logic [7:0] lastD0   = 8'h00;
      logic [7:0] lastD1   = 8'h00;
      forever begin
         @(negedge clock);
         if (!rstN) begin
            lastAddr = 4'h0;
            lastDin  = 8'h00;
            lastD0   = 8'h00;
            lastD1   = 8'h00;
         end else if (monOn) begin
            if (sq.size() > 0 && sq[0].cyc == cyc) begin
               s = sq.pop_front();
               checkOutput("ram_we",   32'(ramWe),   32'(s.we));
               checkOutput("ram_addr", 32'(ramAddr), 32'(s.addr));
               checkOutput("ram_din",  32'(ramDin),  32'(s.din));
               lastAddr = s.addr;
               lastDin  = s.din;
            end else begin
               checkOutput("ram_we_idle",   32'(ramWe),   0);
               checkOutput("ram_addr_hold", 32'(ramAddr), 32'(lastAddr));
               checkOutput("ram_din_hold",  32'(ramDin),  32'(lastDin));
            end
            if (rq0.size() > 0 && rq0[0].cyc == cyc) begin
               r = rq0.pop_front();
               checkOutput("rvalid0", 32'(rvalid0), 1);
               checkOutput("dout0",   32'(dout0),   32'(r.data));
               lastD0 = r.data;
            end else begin
               checkOutput("rvalid0_idle", 32'(rvalid0), 0);
               checkOutput("dout0_hold",   32'(dout0),   32'(lastD0));
            end
            if (rq1.size() > 0 && rq1[0].cyc == cyc) begin
               r = rq1.pop_front();
               checkOutput("rvalid1", 32'(rvalid1), 1);
               checkOutput("dout1",   32'(dout1),   32'(r.data));
               lastD1 = r.data;
            end else begin
               checkOutput("rvalid1_idle", 32'(rvalid1), 0);
               checkOutput("dout1_hold",   32'(dout1),   32'(lastD1));
            end
         end
      end
   end

   // Watchdog against a stuck simulation.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstN = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      applyReset("rst1");

      // Lone write of 10 to address 0, then lone read of it by requester 1.
      drive(1, 1, 4'd0, 8'd10, 0, 0, 0, 0);
      applyStimulus(1, 0, 8'h00);
      drive(0, 0, 0, 0, 1, 0, 4'd0, 8'h00);
      applyStimulus(0, 1, 8'd10);
      idleCycles(4);
      checkOutput("cnt_lone", 32'(conflictCnt), 0);

      // Simultaneous write/read of address 1 straight out of reset.
      applyReset("rst2");
      drive(1, 1, 4'd1, 8'd20, 1, 0, 4'd1, 8'h00);
      applyStimulus(1, 0, 8'h00);
      drive(0, 0, 0, 0, 1, 0, 4'd1, 8'h00);
      applyStimulus(0, 1, 8'd20);
      idleCycles(4);
      checkOutput("cnt_simul", 32'(conflictCnt), 1);

      // Both requesters reading continuously: grants alternate 0,1,0,1,0,1.
      applyReset("rst3");
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, vecA0[i], 8'h55, 1, 0, vecA1[i], 8'h66);
         applyStimulus(vecG0[i], !vecG0[i], vecData[i]);
      end
      idleCycles(4);
      checkOutput("cnt_alt", 32'(conflictCnt), 6);

      // Read granted to requester 0, then reset before its data returns.
      track = 1'b0;
      drive(1, 0, 4'd2, 8'h00, 0, 0, 0, 0);
      applyStimulus(1, 0, 8'h00);
      rstN = 1'b0;
      drive(1, 0, 4'd2, 8'h00, 0, 0, 0, 0);
      #1;
      checkResetOutputs("rst_mid");
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clock);
      #1;
      rstN = 1'b1;
      track = 1'b1;
      idleCycles(4);

      // First tie after reset goes to requester 0; read-after-write returns new data.
      drive(1, 1, 4'd5, 8'h55, 1, 0, 4'd5, 8'h00);
      applyStimulus(1, 0, 8'h00);
      drive(0, 0, 0, 0, 1, 0, 4'd5, 8'h00);
      applyStimulus(0, 1, 8'h55);
      idleCycles(4);
      checkOutput("sq_empty",  32'(sq.size()),  0);
      checkOutput("rq0_empty", 32'(rq0.size()), 0);
      checkOutput("rq1_empty", 32'(rq1.size()), 0);

      // Conflict counter saturation with both requests held.
      applyReset("rst4");
      monOn = 1'b0;
      drive(1, 0, 4'd3, 8'h00, 1, 0, 4'd3, 8'h00);
      repeat (254) @(posedge clock);
      #1;
      checkOutput("cnt_254", 32'(conflictCnt), 254);
      @(posedge clock);
      #1;
      checkOutput("cnt_255", 32'(conflictCnt), 255);
      repeat (45) @(posedge clock);
      #1;
      checkOutput("cnt_sat", 32'(conflictCnt), 255);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
